// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider serving the EX-stage divide
// handshake. EX raises start_i with stable operands and stalls until ready_o.
// One quotient bit is produced per cycle. Signed operands are divided as
// magnitudes, and the signs are fixed up once at the end.
//
// Ports
//   clk           clock, all state on rising edge
//   resetn        asynchronous active-low reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled only on the accepting edge
//   opdata2_i     divisor, sampled only on the accepting edge
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       abort/flush, has priority over start_i everywhere
//   result_o      {remainder, quotient}, zero unless ready_o
//   ready_o       result valid (END state)
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, BYZERO, DIVON, END} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] res;

  logic               go;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     part, diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign go    = start_i & ~annul_i;
  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1  = a_neg ? -opdata1_i : opdata1_i;
  assign abs2  = b_neg ? -opdata2_i : opdata2_i;

  // The partial remainder needs one extra bit. rem < dvs always holds, so
  // part < 2*dvs, and the sign of diff alone decides the quotient bit.
  assign part = {rem, dvd[WIDTH-1]};
  assign diff = part - {1'b0, dvs};

  assign quo_fix = neg_q ? -dvd : dvd;
  assign rem_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = (opdata2_i == '0) ? BYZERO : DIVON;
      BYZERO:  state_nxt = go ? END : IDLE;
      DIVON: begin
        if (!go)                  state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = END;
      end
      END:     if (!go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go && opdata2_i != '0) begin
            dvd   <= abs1;
            dvs   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        BYZERO: res <= '0;
        DIVON: begin
          if (go) begin
            if (cnt != CNT_LAST) begin
              rem <= diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
              dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
              cnt <= cnt + CW'(1);
            end else begin
              // All bits are done. This edge applies the sign fixup on entry to END.
              res <= {rem_fix, quo_fix};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state == END);
  assign result_o = ready_o ? res : '0;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized operations.
// These are checked every cycle against a behavioural arithmetic/latency model.
module tb_div_iter;

  logic        clk, resetn, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  logic        exp_ready;
  logic [63:0] exp_res;
  int          n_chk, n_fail;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {remainder, quotient} by plain 64-bit arithmetic, truncating toward zero
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, just after the active edge
  always @(posedge clk) begin
    #1;
    chk("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
    chk("result_o", result_o, exp_ready ? exp_res : 64'd0);
  end

  task automatic scramble();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
  endtask

  // abort_kind: 0 annul, 1 drop start, 2 reset (at abort_at edges after accept)
  // end_mode:   0 drop start, 1 annul, 2 reset (after hold cycles in END)
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input int abort_at, input int abort_kind, input int hold,
                     input int end_mode, input logic pre_annul);
    int lat;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b;
    start_i = 1'b1; annul_i = pre_annul; exp_ready = 1'b0;
    if (pre_annul) begin
      @(negedge clk);
      annul_i = 1'b0;
    end
    lat = (b == 32'd0) ? 1 : 33;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      scramble();
      if (i == abort_at) begin
        if (abort_kind == 2) begin
          resetn = 1'b0;
          #1;
          chk("rst_ready", {63'd0, ready_o}, 64'd0);
          chk("rst_result", result_o, 64'd0);
          @(negedge clk);
          resetn = 1'b1; start_i = 1'b0;
        end else begin
          if (abort_kind == 0) annul_i = 1'b1;
          else                 start_i = 1'b0;
          @(negedge clk);
          annul_i = 1'b0; start_i = 1'b0;
        end
        return;
      end
      if (i == lat) begin
        exp_ready = 1'b1;
        exp_res   = model(s, a, b);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble();
    end
    @(negedge clk);
    exp_ready = 1'b0;
    if (end_mode == 0) begin
      start_i = 1'b0;
    end else if (end_mode == 1) begin
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
    end else begin
      resetn = 1'b0;
      #1;
      chk("end_rst_ready", {63'd0, ready_o}, 64'd0);
      chk("end_rst_result", result_o, 64'd0);
      @(negedge clk);
      resetn = 1'b1; start_i = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          r, ab_at, ab_k;
    n_chk = 0; n_fail = 0;
    exp_ready = 1'b0; exp_res = 64'd0;
    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);

    // Pin the model with hand-computed values
    chk("pin_u100_7",   model(1'b0, 32'd100, 32'd7),                   64'h00000002_0000000E);
    chk("pin_sm7_2",    model(1'b1, 32'hFFFFFFF9, 32'h2),              64'hFFFFFFFF_FFFFFFFD);
    chk("pin_s7_m2",    model(1'b1, 32'h7, 32'hFFFFFFFE),              64'h00000001_FFFFFFFD);
    chk("pin_sovf",     model(1'b1, 32'h80000000, 32'hFFFFFFFF),       64'h00000000_80000000);
    chk("pin_uovf",     model(1'b0, 32'h80000000, 32'hFFFFFFFF),       64'h80000000_00000000);
    chk("pin_uffff_1",  model(1'b0, 32'hFFFFFFFF, 32'h1),              64'h00000000_FFFFFFFF);
    chk("pin_div0",     model(1'b1, 32'd5, 32'd0),                     64'd0);

    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run(1'b0, 32'd100, 32'd7, -1, 0, 2, 0, 1'b0);
    run(1'b1, 32'hFFFFFFF9, 32'h2, -1, 0, 0, 0, 1'b0);
    run(1'b1, 32'h7, 32'hFFFFFFFE, -1, 0, 1, 0, 1'b0);
    run(1'b0, 32'd5, 32'd0, -1, 0, 1, 0, 1'b0);
    run(1'b1, 32'd5, 32'd0, -1, 0, 0, 0, 1'b0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 0, 0, 0, 1'b0);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, -1, 0, 0, 0, 1'b0);
    run(1'b0, 32'd100, 32'd7, 10, 0, 0, 0, 1'b0);
    run(1'b0, 32'd100, 32'd7, -1, 0, 0, 0, 1'b0);
    run(1'b0, 32'd100, 32'd7, 20, 1, 0, 0, 1'b0);
    run(1'b0, 32'd100, 32'd7, 20, 2, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    run(1'b0, 32'hFFFFFFFF, 32'h1, -1, 0, 0, 0, 1'b0);
    run(1'b1, 32'hFFFFFFF9, 32'h2, -1, 0, 2, 1, 1'b0);
    run(1'b0, 32'd100, 32'd7, -1, 0, 1, 2, 1'b0);
    run(1'b0, 32'd100, 32'd7, -1, 0, 0, 0, 1'b1);

    for (int k = 0; k < 80; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      b = 32'd0;
      else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (r <= 3) b = 32'($urandom_range(1, 15));
      else             b = $urandom;
      ab_at = -1; ab_k = 0;
      if (b != 32'd0 && $urandom_range(0, 3) == 0) begin
        ab_at = $urandom_range(1, 33);
        ab_k  = $urandom_range(0, 2);
      end
      run(s, a, b, ab_at, ab_k, $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom_range(0, 9) == 0));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
